// File: rtl/connect4_pkg.sv
// Shared constants and types for the Connect-4 input path.
//   NUM_COLS      : number of board columns
//   COL_W         : width of a column index
//   col_t         : column index type
//   input_state_t : states of the move input controller
//   cursor_step() : next cursor position for one cycle of left/right presses
package connect4_pkg;

  localparam int NUM_COLS = 7;
  localparam int COL_W    = $clog2(NUM_COLS);

  typedef logic [COL_W-1:0] col_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOCKED  = 2'd2
  } input_state_t;

  // Wraps at both ends. Left and right in the same cycle cancel out.
  function automatic col_t cursor_step(input col_t cur, input logic left, input logic right);
    col_t nxt;
    nxt = cur;
    if (left && !right) begin
      nxt = (cur == '0) ? col_t'(NUM_COLS - 1) : cur - 1'b1;
    end else if (right && !left) begin
      nxt = (cur == col_t'(NUM_COLS - 1)) ? '0 : cur + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Conditions one raw active-low push button.
//   clk    : system clock
//   reset  : asynchronous, active-high
//   key_n  : raw button, low = pressed
//   press  : one-cycle pulse when the debounced level goes from released to pressed
// A level change is accepted only after the synchronized input has differed
// from the accepted level for DEBOUNCE_CYCLES consecutive cycles. Releases
// produce no pulse, so holding a button yields exactly one press.
module key_debounce
  #(parameter int DEBOUNCE_CYCLES = 50000)
  (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
  );

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             press_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
    end
  end

  // Any cycle where the input agrees with the accepted level restarts the
  // count, so glitches shorter than the window never get through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      stable  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        stable  <= sync_2;
        cnt     <= '0;
        press_q <= ~sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/move_input_ctrl.sv
// Player-input front end for Connect-4.
//   clk          : system clock
//   reset        : asynchronous, active-high
//   key_left_n   : raw button, move cursor left (active-low)
//   key_right_n  : raw button, move cursor right (active-low)
//   key_drop_n   : raw button, drop piece in cursor column (active-low)
//   game_over    : no further moves accepted while high
//   col_full     : bit c high = column c is full
//   move_ready   : game FSM accepts the pending move this cycle
//   move_valid   : drop request pending
//   move_col     : column of the pending request, stable while move_valid
//   cursor_col   : current cursor position
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cursor follows left/right presses, drop press issues a move
// PENDING | move_valid high, waiting for move_ready; presses discarded
// LOCKED  | game over, all presses discarded; cursor homes on exit
module move_input_ctrl
  import connect4_pkg::*;
  #(parameter int DEBOUNCE_CYCLES = 50000)
  (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_left_n,
    input  logic                key_right_n,
    input  logic                key_drop_n,
    input  logic                game_over,
    input  logic [NUM_COLS-1:0] col_full,
    input  logic                move_ready,
    output logic                move_valid,
    output logic [COL_W-1:0]    move_col,
    output logic [COL_W-1:0]    cursor_col
  );

  logic press_left;
  logic press_right;
  logic press_drop;

  input_state_t state_q, state_d;
  col_t         cursor_q, cursor_d;
  col_t         move_col_q, move_col_d;
  logic         move_valid_q, move_valid_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk   (clk),
    .reset (reset),
    .key_n (key_left_n),
    .press (press_left)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk   (clk),
    .reset (reset),
    .key_n (key_right_n),
    .press (press_right)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_drop (
    .clk   (clk),
    .reset (reset),
    .key_n (key_drop_n),
    .press (press_drop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cursor_q     <= '0;
      move_col_q   <= '0;
      move_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      move_col_q   <= move_col_d;
      move_valid_q <= move_valid_d;
    end
  end

  // Priority within a cycle: game_over, then handshake, then presses.
  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    move_col_d   = move_col_q;
    move_valid_d = move_valid_q;

    case (state_q)
      IDLE: begin
        move_valid_d = 1'b0;
        if (game_over) begin
          state_d = LOCKED;
        end else begin
          cursor_d = cursor_step(cursor_q, press_left, press_right);
          // Drop uses the pre-move cursor even if the cursor moves this cycle.
          if (press_drop && !col_full[cursor_q]) begin
            state_d      = PENDING;
            move_col_d   = cursor_q;
            move_valid_d = 1'b1;
          end
        end
      end

      PENDING: begin
        // col_full is deliberately not looked at: once issued, a request is
        // only withdrawn by game_over.
        if (game_over) begin
          state_d      = LOCKED;
          move_valid_d = 1'b0;
        end else if (move_ready) begin
          state_d      = IDLE;
          move_valid_d = 1'b0;
        end
      end

      LOCKED: begin
        move_valid_d = 1'b0;
        if (!game_over) begin
          state_d  = IDLE;
          cursor_d = '0;
        end
      end

      default: begin
        state_d      = IDLE;
        move_valid_d = 1'b0;
      end
    endcase
  end

  assign move_valid = move_valid_q;
  assign move_col   = move_col_q;
  assign cursor_col = cursor_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
module tb_move_input_ctrl;

  localparam int DEB    = 4;
  localparam int K_LEFT  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_DROP  = 2;

  logic       clk;
  logic       reset;
  logic       key_left_n;
  logic       key_right_n;
  logic       key_drop_n;
  logic       game_over;
  logic [6:0] col_full;
  logic       move_ready;
  logic       move_valid;
  logic [2:0] move_col;
  logic [2:0] cursor_col;

  int err_cnt;
  int chk_cnt;
  int xfer_cnt;
  logic valid_seen;

  move_input_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_left_n  (key_left_n),
    .key_right_n (key_right_n),
    .key_drop_n  (key_drop_n),
    .game_over   (game_over),
    .col_full    (col_full),
    .move_ready  (move_ready),
    .move_valid  (move_valid),
    .move_col    (move_col),
    .cursor_col  (cursor_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock; records handshakes and any move_valid seen before the edge.
  task automatic tick();
    if (move_valid && move_ready) xfer_cnt++;
    if (move_valid) valid_seen = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      K_LEFT:  key_left_n  = v;
      K_RIGHT: key_right_n = v;
      default: key_drop_n  = v;
    endcase
  endtask

  task automatic press_key(input int k, input int hold);
    set_key(k, 1'b0);
    repeat (hold) tick();
    set_key(k, 1'b1);
    repeat (10) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int xfer_base;
    err_cnt     = 0;
    chk_cnt     = 0;
    xfer_cnt    = 0;
    valid_seen  = 1'b0;
    key_left_n  = 1'b1;
    key_right_n = 1'b1;
    key_drop_n  = 1'b1;
    game_over   = 1'b0;
    col_full    = 7'b0;
    move_ready  = 1'b0;
    reset       = 1'b1;
    #2;
    check("reset_valid_async", move_valid, 0);
    do_reset();

    check("reset_cursor", cursor_col, 0);
    check("reset_valid", move_valid, 0);
    check("reset_move_col", move_col, 0);

    // Cursor walk: 0 -> 1 -> 2 -> 3 -> 2
    valid_seen = 1'b0;
    press_key(K_RIGHT, 10);
    check("walk_r1", cursor_col, 1);
    press_key(K_RIGHT, 10);
    check("walk_r2", cursor_col, 2);
    press_key(K_RIGHT, 10);
    check("walk_r3", cursor_col, 3);
    press_key(K_LEFT, 10);
    check("walk_l1", cursor_col, 2);
    check("walk_no_valid", valid_seen, 0);

    // Wrap both ways
    do_reset();
    press_key(K_LEFT, 10);
    check("wrap_left", cursor_col, 6);
    press_key(K_RIGHT, 10);
    check("wrap_right", cursor_col, 0);

    // Bouncing: 3-cycle low pulses never reach the debounce window
    for (int i = 0; i < 20; i++) begin
      key_right_n = (i % 6) < 3 ? 1'b0 : 1'b1;
      tick();
    end
    key_right_n = 1'b1;
    repeat (10) tick();
    check("bounce_cursor", cursor_col, 0);

    // Long hold gives exactly one press
    press_key(K_RIGHT, 30);
    check("hold_one_press", cursor_col, 1);

    // Cursor to 4, then exact drop latency and handshake timing
    press_key(K_RIGHT, 10);
    press_key(K_RIGHT, 10);
    press_key(K_RIGHT, 10);
    check("cursor_at_4", cursor_col, 4);
    xfer_cnt   = 0;
    move_ready = 1'b0;
    key_drop_n = 1'b0;
    repeat (6) tick();
    check("drop_lat_before", move_valid, 0);
    tick();
    check("drop_lat_valid", move_valid, 1);
    check("drop_lat_col", move_col, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("drop_hold_valid", move_valid, 1);
      check("drop_hold_col", move_col, 4);
    end
    move_ready = 1'b1;
    tick();
    move_ready = 1'b0;
    check("drop_done_valid", move_valid, 0);
    check("drop_xfer_one", xfer_cnt, 1);
    key_drop_n = 1'b1;
    repeat (10) tick();

    // Second drop while PENDING is discarded
    xfer_base = xfer_cnt;
    press_key(K_DROP, 10);
    check("pend_valid", move_valid, 1);
    press_key(K_DROP, 10);
    check("pend_no_xfer_yet", xfer_cnt - xfer_base, 0);
    move_ready = 1'b1;
    tick();
    move_ready = 1'b0;
    repeat (20) tick();
    check("pend_single_xfer", xfer_cnt - xfer_base, 1);
    check("pend_valid_low", move_valid, 0);

    // Full column: 4 -> 2 (full), drop ignored; 3, drop accepted
    press_key(K_LEFT, 10);
    press_key(K_LEFT, 10);
    check("full_cursor2", cursor_col, 2);
    col_full   = 7'b0000100;
    valid_seen = 1'b0;
    press_key(K_DROP, 10);
    repeat (10) tick();
    check("full_ignored", valid_seen, 0);
    press_key(K_RIGHT, 10);
    check("full_cursor3", cursor_col, 3);
    press_key(K_DROP, 10);
    check("full_valid", move_valid, 1);
    check("full_move_col", move_col, 3);
    col_full = 7'b0001100;
    repeat (3) tick();
    check("full_change_kept", move_valid, 1);
    col_full   = 7'b0;
    move_ready = 1'b1;
    tick();
    move_ready = 1'b0;
    check("full_done", move_valid, 0);

    // Game over withdraws request and locks input
    press_key(K_DROP, 10);
    check("go_pending", move_valid, 1);
    game_over = 1'b1;
    tick();
    check("go_withdraw", move_valid, 0);
    valid_seen = 1'b0;
    move_ready = 1'b1;
    press_key(K_RIGHT, 10);
    press_key(K_DROP, 10);
    move_ready = 1'b0;
    check("go_cursor_frozen", cursor_col, 3);
    check("go_no_valid", valid_seen, 0);
    game_over = 1'b0;
    tick();
    check("go_cursor_home", cursor_col, 0);

    // Async reset mid-PENDING
    press_key(K_RIGHT, 10);
    press_key(K_DROP, 10);
    check("ar_pending", move_valid, 1);
    check("ar_pending_col", move_col, 1);
    #3;
    reset = 1'b1;
    #1;
    check("ar_valid_now", move_valid, 0);
    check("ar_cursor_now", cursor_col, 0);
    check("ar_col_now", move_col, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) tick();
    check("ar_stays_idle", move_valid, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
